rx_byte_aligner: RTL and testbench
==================================

# rx_byte_aligner

Synthesizable 16-bit comma byte aligner between the GT receiver ports (`rxdata`/`rxcharisk` after the elastic buffer) and the latency/link checker downstream. It finds the IDLE comma in either byte lane, locks to it after a run of consistent IDLEs, and re-packs the stream so the comma always sits in the upper byte with `rx_k_o == 2'b10`. It also reports alignment status and drops lock on errors, timeout or an explicit realign request.

## Interface
- `g_IDLE`, 16'hbc95: IDLE word; the upper byte is the K comma and the lower byte is data.
- `g_LOCK_COUNT`, 4: consecutive same-lane IDLE hits required to lock; minimum 1.
- `g_UNLOCK_COUNT`, 3: consecutive bad words in LOCKED that force unlock.
- `g_IDLE_TIMEOUT`, 1024: cycles without a tracked-lane hit before unlock.

Ports:
- `usrclk_i`  in  1  GT user clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `rx_data_i`  in  16  raw GT data.
- `rx_k_i`  in  2  raw charisk; bit1 marks the upper byte.
- `realign_i`  in  1  level request to drop lock and re-search.
- `rx_data_o`  out  16  aligned data.
- `rx_k_o`  out  2  aligned charisk.
- `aligned_o`  out  1  high in LOCKED.
- `offset_o`  out  1  applied lane offset: 0 = no shift, 1 = one-byte shift.
- `unlock_cnt_o`  out  16  error/timeout unlock events, saturating.

## Operation
- **Datapath**
  - Capture register `d1` and `d1_k` hold the previous input word.
  - Offset 0: output ← `d1`.
  - Offset 1: output ← `{d1[7:0], rx_data_i[15:8]}`, and k ← `{d1_k[0], rx_k_i[1]}`.
- **Hit detection** (combinational on `d1` and the input)
  - hit0: `d1_k==2'b10 && d1==g_IDLE`.
  - hit1: `d1_k[0]==1 && d1[7:0]==g_IDLE[15:8] && rx_k_i[1]==0 && rx_data_i[15:8]==g_IDLE[7:0]`.
  - If both fire in the same cycle, hit0 wins.
- **Bad word** (offset L): any set K bit in the word the output would produce at offset L, other than a hit at L. This includes a hit at the other lane.
- **FSM**
  - UNLOCKED: on hitX → CANDIDATE with `cand=X`, `cnt=1`.
  - CANDIDATE:
    - hit at `cand` → `cnt++`.
    - On the edge where `cnt` reaches `g_LOCK_COUNT` → LOCKED, `offset←cand`, `err_run=0`.
    - Hit only at the other lane → `cand` swaps and `cnt=1`.
  - LOCKED:
    - hit at the offset → `err_run=0`.
    - Bad word → `err_run++`; at `g_UNLOCK_COUNT` → UNLOCKED and `unlock_cnt_o++`.
- **Timeout:** the counter resets on each hit at the tracked lane (`cand` in CANDIDATE, offset in LOCKED) and on any state change. Reaching `g_IDLE_TIMEOUT` → UNLOCKED, and `unlock_cnt_o++` if leaving LOCKED.
- **Realign:** `realign_i=1` in any state → UNLOCKED next edge, overriding all other transitions. It does not count as an unlock event.
- **Offset while unlocked:** `offset_o` keeps its last value; data keeps flowing and `aligned_o=0`.
- **Counter width:** `unlock_cnt_o` saturates at 16'hFFFF.
- **Lock count of 1:** `g_LOCK_COUNT=1` goes UNLOCKED → LOCKED directly on the first hit.

## Timing
- **Reset values:** state UNLOCKED, `aligned_o=0`, `offset_o=0`, `unlock_cnt_o=0`, `rx_data_o=g_IDLE`, `rx_k_o=2'b10`, `d1=0`, all counters 0.
- **Latency:** a comma byte entering at edge n appears in `rx_data_o[15:8]` at edge n+2, for either offset.
- **Lock edge:** `aligned_o` and `offset_o` update on the same edge as the LOCKED transition. The output word registered on that edge still uses the old offset; the first re-packed word appears one edge later.
- **Leaving LOCKED:** `aligned_o` falls on the same edge the FSM leaves LOCKED, including the realign case.
- **Reset mid-stream:** all state clears in one edge; the next hit restarts the search.

## Test plan
- **Clean offset 0:** IDLE (k=10) every 8 words, data otherwise → `aligned_o` rises the edge after the 4th IDLE. `offset_o=0`. Payload word 16'h1234 emerges unchanged 2 cycles later.
- **Byte-shifted:** same stream delayed by one byte (comma in the lower lane) → lock with `offset_o=1`. Output shows 16'hbc95 with k=10, and payload re-packed byte-exact.
- **Error unlock:** while LOCKED, inject 3 consecutive words with `rx_k_i=2'b01` → `aligned_o` drops on the 3rd, `unlock_cnt_o=1`. With only 2 bad words followed by an IDLE, lock is held.
- **Timeout:** stop sending IDLEs in LOCKED → unlock after 1024 cycles, `unlock_cnt_o` increments. Restoring IDLEs re-locks after 4 hits.
- **Realign/reset:** pulse `realign_i` in LOCKED → `aligned_o=0` next edge with `unlock_cnt_o` unchanged. Assert `rst_i` in CANDIDATE → all outputs return to reset values.
- **Lane conflict:** alternate hit0/hit1 in CANDIDATE → never locks and `cand` tracks the latest lane. A cycle with simultaneous hit0 and hit1 counts as a hit0.

Source files
------------

// File: rtl/rx_byte_aligner.sv
// 16-bit comma byte aligner: finds the IDLE comma in either lane, locks after a run
// of consistent hits and re-packs the stream so the comma always lands in the upper byte.
module rx_byte_aligner #(
    parameter logic [15:0] g_IDLE         = 16'hbc95,
    parameter int          g_LOCK_COUNT   = 4,
    parameter int          g_UNLOCK_COUNT = 3,
    parameter int          g_IDLE_TIMEOUT = 1024
) (
    input  logic        usrclk_i,
    input  logic        rst_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic        realign_i,
    output logic [15:0] rx_data_o,
    output logic [1:0]  rx_k_o,
    output logic        aligned_o,
    output logic        offset_o,
    output logic [15:0] unlock_cnt_o
);

    localparam int CW = $clog2(g_LOCK_COUNT + 1);
    localparam int EW = $clog2(g_UNLOCK_COUNT + 1);
    localparam int TW = $clog2(g_IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] LOCK_LAST    = CW'(g_LOCK_COUNT - 1);
    localparam logic [EW-1:0] UNLOCK_LAST  = EW'(g_UNLOCK_COUNT - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(g_IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CANDIDATE,
        ST_LOCKED
    } state_t;

    state_t        r_state;
    logic [15:0]   r_d1;
    logic [1:0]    r_d1_k;
    logic [15:0]   r_data;
    logic [1:0]    r_k;
    logic          r_aligned;
    logic          r_offset;
    logic          r_cand;
    logic [CW-1:0] r_cnt;
    logic [EW-1:0] r_err_run;
    logic [TW-1:0] r_timeout;
    logic [15:0]   r_unlock_cnt;

    logic          w_hit0;
    logic          w_hit1;
    logic          w_hit_any;
    logic          w_hit_cand;
    logic          w_hit_off;
    logic [15:0]   w_shift_data;
    logic [1:0]    w_shift_k;
    logic [1:0]    w_k_off;
    logic          w_bad;

    // hit0 and hit1 need contradictory d1_k values; the priority only documents intent
    assign w_hit0 = (r_d1_k == 2'b10) && (r_d1 == g_IDLE);
    assign w_hit1 = !w_hit0 && r_d1_k[0] && (r_d1[7:0] == g_IDLE[15:8]) &&
                    !rx_k_i[1] && (rx_data_i[15:8] == g_IDLE[7:0]);
    assign w_hit_any  = w_hit0 | w_hit1;
    assign w_hit_cand = r_cand ? w_hit1 : w_hit0;
    assign w_hit_off  = r_offset ? w_hit1 : w_hit0;

    assign w_shift_data = {r_d1[7:0], rx_data_i[15:8]};
    assign w_shift_k    = {r_d1_k[0], rx_k_i[1]};
    assign w_k_off      = r_offset ? w_shift_k : r_d1_k;
    assign w_bad        = (w_k_off != 2'b00) && !w_hit_off;

    always_ff @(posedge usrclk_i) begin
        if (rst_i) begin
            r_state      <= ST_UNLOCKED;
            r_d1         <= '0;
            r_d1_k       <= '0;
            r_data       <= g_IDLE;
            r_k          <= 2'b10;
            r_aligned    <= 1'b0;
            r_offset     <= 1'b0;
            r_cand       <= 1'b0;
            r_cnt        <= '0;
            r_err_run    <= '0;
            r_timeout    <= '0;
            r_unlock_cnt <= '0;
        end else begin
            r_d1   <= rx_data_i;
            r_d1_k <= rx_k_i;
            r_data <= r_offset ? w_shift_data : r_d1;
            r_k    <= r_offset ? w_shift_k : r_d1_k;

            if (realign_i) begin
                r_state   <= ST_UNLOCKED;
                r_aligned <= 1'b0;
                r_cnt     <= '0;
                r_err_run <= '0;
                r_timeout <= '0;
            end else begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_hit_any) begin
                            r_cand    <= w_hit1;
                            r_cnt     <= CW'(1);
                            r_timeout <= '0;
                            if (g_LOCK_COUNT == 1) begin
                                r_state   <= ST_LOCKED;
                                r_aligned <= 1'b1;
                                r_offset  <= w_hit1;
                                r_err_run <= '0;
                            end else begin
                                r_state <= ST_CANDIDATE;
                            end
                        end
                    end
                    ST_CANDIDATE: begin
                        if (w_hit_cand) begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_timeout <= '0;
                            if (r_cnt == LOCK_LAST) begin
                                r_state   <= ST_LOCKED;
                                r_aligned <= 1'b1;
                                r_offset  <= r_cand;
                                r_err_run <= '0;
                            end
                        end else if (w_hit_any) begin
                            r_cand    <= w_hit1;
                            r_cnt     <= CW'(1);
                            r_timeout <= '0;
                        end else if (r_timeout == TIMEOUT_LAST) begin
                            r_state   <= ST_UNLOCKED;
                            r_cnt     <= '0;
                            r_timeout <= '0;
                        end else begin
                            r_timeout <= r_timeout + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_hit_off) begin
                            r_err_run <= '0;
                            r_timeout <= '0;
                        end else if ((w_bad && r_err_run == UNLOCK_LAST) ||
                                     r_timeout == TIMEOUT_LAST) begin
                            // error run and timeout on the same edge still count as one event
                            r_state   <= ST_UNLOCKED;
                            r_aligned <= 1'b0;
                            r_cnt     <= '0;
                            r_err_run <= '0;
                            r_timeout <= '0;
                            if (r_unlock_cnt != 16'hFFFF)
                                r_unlock_cnt <= r_unlock_cnt + 1'b1;
                        end else begin
                            r_timeout <= r_timeout + 1'b1;
                            if (w_bad)
                                r_err_run <= r_err_run + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_UNLOCKED;
                        r_aligned <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data_o    = r_data;
    assign rx_k_o       = r_k;
    assign aligned_o    = r_aligned;
    assign offset_o     = r_offset;
    assign unlock_cnt_o = r_unlock_cnt;

endmodule

// File: tb/tb_rx_byte_aligner.sv
// Bench for rx_byte_aligner: a per-edge behavioural model checked every cycle,
// plus literal expectations at key points of each directed scenario.
module tb_rx_byte_aligner;

    localparam logic [15:0] IDLE      = 16'hbc95;
    localparam int          LOCK_N    = 4;
    localparam int          UNLOCK_N  = 3;
    localparam int          TIMEOUT_N = 1024;

    logic        clk;
    logic        rstI;
    logic        realign;
    logic [15:0] rxData;
    logic [1:0]  rxK;

    logic [15:0] dataO;
    logic [1:0]  kO;
    logic        alignedO;
    logic        offsetO;
    logic [15:0] unlockO;

    logic [15:0] data1;
    logic [1:0]  k1;
    logic        aligned1;
    logic        offset1;
    logic [15:0] unlock1;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    rx_byte_aligner dut (
        .usrclk_i     (clk),
        .rst_i        (rstI),
        .rx_data_i    (rxData),
        .rx_k_i       (rxK),
        .realign_i    (realign),
        .rx_data_o    (dataO),
        .rx_k_o       (kO),
        .aligned_o    (alignedO),
        .offset_o     (offsetO),
        .unlock_cnt_o (unlockO)
    );

    rx_byte_aligner #(.g_LOCK_COUNT(1)) dutLock1 (
        .usrclk_i     (clk),
        .rst_i        (rstI),
        .rx_data_i    (rxData),
        .rx_k_i       (rxK),
        .realign_i    (realign),
        .rx_data_o    (data1),
        .rx_k_o       (k1),
        .aligned_o    (aligned1),
        .offset_o     (offset1),
        .unlock_cnt_o (unlock1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: previous word, registered outputs and the search/lock bookkeeping
    logic [15:0] mPrevW, mOutW, mUnlocks;
    logic [1:0]  mPrevK, mOutK;
    logic        mAligned, mOffset, mHaveCand, mCand;
    int          mHits, mErrs, mQuiet;

    always @(posedge clk) begin : model
        logic        h0, h1, hitOff;
        logic [15:0] shW;
        logic [1:0]  shK, kOff;
        if (rstI) begin
            mPrevW = 16'h0; mPrevK = 2'b00; mOutW = IDLE; mOutK = 2'b10;
            mAligned = 0; mOffset = 0; mUnlocks = 16'h0;
            mHaveCand = 0; mCand = 0; mHits = 0; mErrs = 0; mQuiet = 0;
        end else begin
            h0  = (mPrevK == 2'b10) && (mPrevW == IDLE);
            h1  = !h0 && mPrevK[0] && (mPrevW[7:0] == IDLE[15:8]) &&
                  !rxK[1] && (rxData[15:8] == IDLE[7:0]);
            shW = {mPrevW[7:0], rxData[15:8]};
            shK = {mPrevK[0], rxK[1]};
            mOutW = mOffset ? shW : mPrevW;
            mOutK = mOffset ? shK : mPrevK;
            if (realign) begin
                mAligned = 0; mHaveCand = 0; mHits = 0; mErrs = 0; mQuiet = 0;
            end else if (mAligned) begin
                hitOff = mOffset ? h1 : h0;
                kOff   = mOffset ? shK : mPrevK;
                if (hitOff) begin
                    mErrs = 0; mQuiet = 0;
                end else begin
                    mQuiet++;
                    if (kOff != 2'b00) mErrs++;
                    if (mErrs == UNLOCK_N || mQuiet == TIMEOUT_N) begin
                        mAligned = 0; mErrs = 0; mQuiet = 0; mHits = 0;
                        if (mUnlocks != 16'hFFFF) mUnlocks++;
                    end
                end
            end else if (mHaveCand) begin
                if (mCand ? h1 : h0) begin
                    mHits++; mQuiet = 0;
                    if (mHits == LOCK_N) begin
                        mAligned = 1; mOffset = mCand; mHaveCand = 0; mErrs = 0;
                    end
                end else if (h0 || h1) begin
                    mCand = h1; mHits = 1; mQuiet = 0;
                end else begin
                    mQuiet++;
                    if (mQuiet == TIMEOUT_N) begin
                        mHaveCand = 0; mHits = 0; mQuiet = 0;
                    end
                end
            end else if (h0 || h1) begin
                mHaveCand = 1; mCand = h1; mHits = 1; mQuiet = 0;
            end
            mPrevW = rxData;
            mPrevK = rxK;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model rx_data_o", dataO, mOutW);
            checkOutput("model rx_k_o", kO, mOutK);
            checkOutput("model aligned_o", alignedO, mAligned);
            checkOutput("model offset_o", offsetO, mOffset);
            checkOutput("model unlock_cnt_o", unlockO, mUnlocks);
        end
    end

    task automatic applyStimulus(input logic [15:0] w, input logic [1:0] k, input logic re);
        @(negedge clk);
        rxData  = w;
        rxK     = k;
        realign = re;
    endtask

    task automatic sendFrame(input bit lane, input logic [15:0] payload);
        if (!lane) begin
            applyStimulus(IDLE, 2'b10, 1'b0);
            applyStimulus(payload, 2'b00, 1'b0);
            for (int i = 0; i < 6; i++) applyStimulus({8'(i), 8'ha5}, 2'b00, 1'b0);
        end else begin
            applyStimulus({8'h5a, IDLE[15:8]}, 2'b01, 1'b0);
            applyStimulus({IDLE[7:0], payload[15:8]}, 2'b00, 1'b0);
            applyStimulus({payload[7:0], 8'h11}, 2'b00, 1'b0);
            for (int i = 0; i < 5; i++) applyStimulus({8'h22, 8'(i)}, 2'b00, 1'b0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rx_data_o"}, dataO, IDLE);
        checkOutput({tag, " rx_k_o"}, kO, 2'b10);
        checkOutput({tag, " aligned_o"}, alignedO, 1'b0);
        checkOutput({tag, " offset_o"}, offsetO, 1'b0);
        checkOutput({tag, " unlock_cnt_o"}, unlockO, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got t=%0t, limit 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstI = 1'b1; realign = 1'b0; rxData = 16'h0; rxK = 2'b00;
        @(negedge clk);
        checkResetValues("reset");
        checkEn = 1;
        rstI = 1'b0;

        $display("[TB] clean offset 0 and lock-count-1 instance");
        applyStimulus(IDLE, 2'b10, 1'b0);
        applyStimulus(16'h1234, 2'b00, 1'b0);
        checkOutput("lock1 aligned before", aligned1, 1'b0);
        applyStimulus(16'h0001, 2'b00, 1'b0);
        checkOutput("lock1 aligned", aligned1, 1'b1);
        checkOutput("lock1 offset", offset1, 1'b0);
        applyStimulus(16'h0002, 2'b00, 1'b0);
        checkOutput("payload offset0 data", dataO, 16'h1234);
        checkOutput("payload offset0 k", kO, 2'b00);
        for (int i = 0; i < 4; i++) applyStimulus(16'h0003, 2'b00, 1'b0);
        sendFrame(0, 16'h4321);
        sendFrame(0, 16'h4321);
        checkOutput("three hits no lock", alignedO, 1'b0);
        sendFrame(0, 16'h4321);
        checkOutput("four hits lock", alignedO, 1'b1);
        checkOutput("lock offset 0", offsetO, 1'b0);

        $display("[TB] error unlock");
        applyStimulus(16'h0000, 2'b01, 1'b0);
        applyStimulus(16'h0000, 2'b01, 1'b0);
        sendFrame(0, 16'h5555);
        checkOutput("two bad held", alignedO, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 2'b01, 1'b0);
        applyStimulus(16'h0007, 2'b00, 1'b0);
        checkOutput("third bad pending", alignedO, 1'b1);
        applyStimulus(16'h0007, 2'b00, 1'b0);
        checkOutput("three bad drop", alignedO, 1'b0);
        checkOutput("error unlock count", unlockO, 16'd1);

        $display("[TB] timeout");
        for (int i = 0; i < 4; i++) sendFrame(0, 16'h6666);
        checkOutput("relock before timeout", alignedO, 1'b1);
        for (int i = 0; i < 1000; i++) applyStimulus(16'h0a0a, 2'b00, 1'b0);
        checkOutput("no early timeout", alignedO, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(16'h0a0a, 2'b00, 1'b0);
        checkOutput("timeout drop", alignedO, 1'b0);
        checkOutput("timeout unlock count", unlockO, 16'd2);
        for (int i = 0; i < 4; i++) sendFrame(0, 16'h7777);
        checkOutput("relock after timeout", alignedO, 1'b1);

        $display("[TB] realign");
        applyStimulus(16'h0b0b, 2'b00, 1'b1);
        applyStimulus(16'h0b0b, 2'b00, 1'b0);
        checkOutput("realign drop", alignedO, 1'b0);
        checkOutput("realign count kept", unlockO, 16'd2);

        $display("[TB] byte-shifted stream");
        for (int i = 0; i < 3; i++) sendFrame(1, 16'h9999);
        checkOutput("shifted three hits", alignedO, 1'b0);
        applyStimulus({8'h5a, IDLE[15:8]}, 2'b01, 1'b0);
        applyStimulus({IDLE[7:0], 8'h12}, 2'b00, 1'b0);
        applyStimulus({8'h34, 8'h11}, 2'b00, 1'b0);
        checkOutput("shifted lock", alignedO, 1'b1);
        checkOutput("shifted offset", offsetO, 1'b1);
        checkOutput("lock edge old offset", dataO, 16'h5abc);
        applyStimulus(16'h2200, 2'b00, 1'b0);
        checkOutput("repacked payload", dataO, 16'h1234);
        for (int i = 0; i < 4; i++) applyStimulus(16'h2201, 2'b00, 1'b0);
        applyStimulus({8'h5a, IDLE[15:8]}, 2'b01, 1'b0);
        applyStimulus({IDLE[7:0], 8'hab}, 2'b00, 1'b0);
        applyStimulus({8'hcd, 8'h11}, 2'b00, 1'b0);
        checkOutput("repacked comma data", dataO, IDLE);
        checkOutput("repacked comma k", kO, 2'b10);
        applyStimulus(16'h2202, 2'b00, 1'b0);
        checkOutput("repacked payload 2", dataO, 16'habcd);
        for (int i = 0; i < 4; i++) applyStimulus(16'h2203, 2'b00, 1'b0);

        $display("[TB] reset in candidate");
        applyStimulus(16'h0c0c, 2'b00, 1'b1);
        sendFrame(1, 16'h1111);
        sendFrame(1, 16'h1111);
        @(negedge clk);
        rstI = 1'b1; realign = 1'b0; rxData = 16'h0; rxK = 2'b00;
        @(negedge clk);
        rstI = 1'b0;
        checkResetValues("mid reset");
        for (int i = 0; i < 3; i++) sendFrame(0, 16'h2222);
        checkOutput("post reset three hits", alignedO, 1'b0);
        sendFrame(0, 16'h2222);
        checkOutput("post reset lock", alignedO, 1'b1);

        $display("[TB] lane conflict");
        applyStimulus(16'h0d0d, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) sendFrame(i[0], 16'h3333);
        checkOutput("alternating no lock", alignedO, 1'b0);
        sendFrame(1, 16'h3333);
        sendFrame(1, 16'h3333);
        checkOutput("latest lane three hits", alignedO, 1'b0);
        sendFrame(1, 16'h3333);
        checkOutput("latest lane lock", alignedO, 1'b1);
        checkOutput("latest lane offset", offsetO, 1'b1);

        @(negedge clk);
        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
